// File: rtl/matrix_load_control_if.sv
// Stream, operand-memory write and multiply-controller handshake signals of the matrix loader.
// The master side drives the stream and mmc_done; the slave side is the loader itself.
interface matrix_load_control_if #(
    parameter int unsigned N     = 32,
    parameter int unsigned DW    = 8,
    parameter int unsigned LANES = 4
);
    localparam int unsigned AW  = $clog2(N * N);
    localparam int unsigned BAW = $clog2(N * N / LANES);
    localparam int unsigned BW  = DW * LANES;

    logic           go;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           we_A;
    logic [AW-1:0]  addr_A;
    logic [DW-1:0]  DI_A;
    logic           we_B;
    logic [BAW-1:0] addr_B;
    logic [BW-1:0]  DI_B;
    logic           start;
    logic           mmc_done;
    logic           busy;
    logic           load_done;

    modport master (
        output go, in_valid, in_data, mmc_done,
        input  in_ready, we_A, addr_A, DI_A, we_B, addr_B, DI_B, start, busy, load_done
    );

    modport slave (
        input  go, in_valid, in_data, mmc_done,
        output in_ready, we_A, addr_A, DI_A, we_B, addr_B, DI_B, start, busy, load_done
    );
endinterface

// File: rtl/matrix_load_control.sv
// Byte-stream loader for the matrix-multiply operands: fills A, packs and fills B, then kicks
// the multiply controller and waits for its done pulse.
module matrix_load_control #(
    parameter int unsigned N     = 32,
    parameter int unsigned DW    = 8,
    parameter int unsigned LANES = 4
) (
    input logic                  clk,
    input logic                  rst,
    matrix_load_control_if.slave bus
);
    localparam int unsigned AW  = $clog2(N * N);
    localparam int unsigned BAW = $clog2(N * N / LANES);
    localparam int unsigned BW  = DW * LANES;
    localparam int unsigned LW  = $clog2(LANES);
    localparam int unsigned PW  = DW * (LANES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StKick,
        StWaitMmc
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pack_q, pack_d;
    logic           we_a_q, we_a_d;
    logic [AW-1:0]  addr_a_q, addr_a_d;
    logic [DW-1:0]  di_a_q, di_a_d;
    logic           we_b_q, we_b_d;
    logic [BAW-1:0] addr_b_q, addr_b_d;
    logic [BW-1:0]  di_b_q, di_b_d;
    logic           start_q, start_d;
    logic           load_done_q, load_done_d;
    logic           busy_q, busy_d;

    logic          in_ready;
    logic          accept;
    logic          last_byte;
    logic [LW-1:0] lane;

    assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
    assign accept    = bus.in_valid && in_ready;
    assign last_byte = (cnt_q == AW'(N * N - 1));
    assign lane      = cnt_q[LW-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        we_a_d      = 1'b0;
        addr_a_d    = addr_a_q;
        di_a_d      = di_a_q;
        we_b_d      = 1'b0;
        addr_b_d    = addr_b_q;
        di_b_d      = di_b_q;
        start_d     = 1'b0;
        load_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.go) begin
                    state_d = StLoadA;
                    cnt_d   = '0;
                end
            end
            StLoadA: begin
                if (accept) begin
                    we_a_d   = 1'b1;
                    addr_a_d = cnt_q;
                    di_a_d   = bus.in_data;
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            StLoadB: begin
                if (accept) begin
                    if (lane == LW'(LANES - 1)) begin
                        we_b_d   = 1'b1;
                        addr_b_d = cnt_q[AW-1:LW];
                        di_b_d   = {pack_q, bus.in_data};
                    end else begin
                        // Lane 0 lands in the most significant byte of the packed word.
                        for (int l = 0; l < int'(LANES) - 1; l++) begin
                            if (lane == LW'(l)) begin
                                pack_d[PW-1-l*DW -: DW] = bus.in_data;
                            end
                        end
                    end
                    if (last_byte) begin
                        cnt_d   = '0;
                        state_d = StKick;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            StKick: begin
                start_d = 1'b1;
                state_d = StWaitMmc;
            end
            StWaitMmc: begin
                // A done pulse coincident with our own start cannot belong to this run.
                if (bus.mmc_done && !start_q) begin
                    load_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Held through the load_done cycle even though the FSM is already back in idle.
        busy_d = (state_d != StIdle) || load_done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            pack_q      <= '0;
            we_a_q      <= 1'b0;
            addr_a_q    <= '0;
            di_a_q      <= '0;
            we_b_q      <= 1'b0;
            addr_b_q    <= '0;
            di_b_q      <= '0;
            start_q     <= 1'b0;
            load_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            we_a_q      <= we_a_d;
            addr_a_q    <= addr_a_d;
            di_a_q      <= di_a_d;
            we_b_q      <= we_b_d;
            addr_b_q    <= addr_b_d;
            di_b_q      <= di_b_d;
            start_q     <= start_d;
            load_done_q <= load_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.we_A      = we_a_q;
    assign bus.addr_A    = addr_a_q;
    assign bus.DI_A      = di_a_q;
    assign bus.we_B      = we_b_q;
    assign bus.addr_B    = addr_b_q;
    assign bus.DI_B      = di_b_q;
    assign bus.start     = start_q;
    assign bus.load_done = load_done_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_matrix_load_control.sv
// Directed bench for matrix_load_control: full-rate and backpressured loads, start/done timing,
// mid-load reset, spurious go/mmc_done and a back-to-back restart.
module tb_matrix_load_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_load_control_if bus ();
    matrix_load_control dut (.clk(clk), .rst(rst), .bus(bus));

    int passes = 0;
    int checks = 0;

    logic [9:0]  wa_addr[$];
    logic [7:0]  wa_data[$];
    logic [7:0]  wb_addr[$];
    logic [31:0] wb_data[$];
    int run_a = 0, max_run_a = 0, n_start = 0, n_ld = 0;

    // Write log captured mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.we_A === 1'b1) begin
            wa_addr.push_back(bus.addr_A);
            wa_data.push_back(bus.DI_A);
            run_a = run_a + 1;
            if (run_a > max_run_a) max_run_a = run_a;
        end else begin
            run_a = 0;
        end
        if (bus.we_B === 1'b1) begin
            wb_addr.push_back(bus.addr_B);
            wb_data.push_back(bus.DI_B);
        end
        if (bus.start === 1'b1) n_start = n_start + 1;
        if (bus.load_done === 1'b1) n_ld = n_ld + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs();
        return {bus.in_ready, bus.we_A, bus.addr_A, bus.DI_A, bus.we_B, bus.addr_B, bus.DI_B,
                bus.start, bus.busy, bus.load_done};
    endfunction

    function automatic logic [7:0] dat(input int sel, input int n);
        case (sel)
            0:       return 8'(n);
            1:       return 8'(n + 1);
            2:       return 8'(n ^ 8'h5A);
            3:       return 8'(n * 3);
            4:       return 8'(n + 7);
            default: return 8'hEE;
        endcase
    endfunction

    // Offer count bytes; optional random in_valid; go/mmc_done pulsed while byte go_at/mmc_at is offered.
    task automatic stream(input int sel, input int count, input bit rnd, input int go_at,
                          input int mmc_at);
        int n = 0;
        int guard = 0;
        bit v, acc;
        while (n < count && guard < count * 20) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = dat(sel, n);
            bus.go       = (n == go_at);
            bus.mmc_done = (n == mmc_at);
            acc = v && (bus.in_ready === 1'b1);
            step();
            guard++;
            if (acc) n++;
        end
        bus.in_valid = 1'b0;
        bus.go       = 1'b0;
        bus.mmc_done = 1'b0;
        chk("stream_accepted", 64'(n), 64'(count));
    endtask

    task automatic check_a(input int base, input int sel, input string tag);
        int err = 0;
        chk({tag, "_count"}, 64'(wa_addr.size() - base), 64'd1024);
        for (int i = 0; i < 1024 && base + i < wa_addr.size(); i++) begin
            if (wa_addr[base+i] !== 10'(i) || wa_data[base+i] !== dat(sel, i)) err++;
        end
        chk({tag, "_image_errors"}, 64'(err), 64'd0);
    endtask

    task automatic check_b(input int base, input int sel, input string tag);
        int err = 0;
        logic [31:0] w;
        chk({tag, "_count"}, 64'(wb_addr.size() - base), 64'd256);
        for (int i = 0; i < 256 && base + i < wb_addr.size(); i++) begin
            w = {dat(sel, 4 * i), dat(sel, 4 * i + 1), dat(sel, 4 * i + 2), dat(sel, 4 * i + 3)};
            if (wb_addr[base+i] !== 8'(i) || wb_data[base+i] !== w) err++;
        end
        chk({tag, "_image_errors"}, 64'(err), 64'd0);
    endtask

    int base_a, base_b, ld0;

    initial begin
        rst          = 1'b1;
        bus.go       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.mmc_done = 1'b0;
        repeat (3) step();
        chk("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_outputs", outs(), 64'd0);

        // Sequence 1: full-rate A with a stray go, backpressured B with a stray mmc_done.
        base_a = wa_addr.size();
        base_b = wb_addr.size();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("go_busy_ready", {62'd0, bus.busy, bus.in_ready}, 64'b11);
        stream(0, 1024, 1'b0, 500, -1);
        chk("a_last_write", {52'd0, bus.we_A, bus.addr_A, bus.we_B}, {52'd0, 1'b1, 10'd1023, 1'b0});
        stream(1, 1024, 1'b1, -1, 100);
        // Now in cycle t+1 after the final B byte was accepted at t.
        chk("t1_final_we_b", {53'd0, bus.we_B, bus.addr_B, bus.in_ready, bus.start},
            {53'd0, 1'b1, 8'd255, 1'b0, 1'b0});
        chk("no_start_during_load", 64'(n_start), 64'd0);
        chk("no_load_done_during_load", 64'(n_ld), 64'd0);
        step();
        chk("t2_start", {60'd0, bus.start, bus.we_B, bus.in_ready, bus.busy}, 64'b1001);
        bus.mmc_done = 1'b1;   // coincides with start: must be ignored
        step();
        bus.mmc_done = 1'b0;
        chk("t3_start_gone", {61'd0, bus.start, bus.load_done, bus.busy}, 64'b001);
        repeat (7) step();
        chk("t10_waiting", {62'd0, bus.load_done, bus.busy}, 64'b01);
        bus.mmc_done = 1'b1;
        step();
        bus.mmc_done = 1'b0;
        chk("t11_load_done", {61'd0, bus.load_done, bus.busy, bus.start}, 64'b110);
        step();
        chk("t12_idle", {62'd0, bus.load_done, bus.busy}, 64'b00);
        check_a(base_a, 0, "seq1_a");
        chk("seq1_a_consecutive", 64'(max_run_a), 64'd1024);
        check_b(base_b, 1, "seq1_b");
        chk("seq1_first_b", {24'd0, wb_addr[base_b], wb_data[base_b]}, {24'd0, 8'd0, 32'h01020304});
        chk("seq1_one_start", 64'(n_start), 64'd1);
        chk("seq1_one_load_done", 64'(n_ld), 64'd1);

        // Sequence 2: backpressured A, then reset with a partial second B word pending.
        base_a = wa_addr.size();
        base_b = wb_addr.size();
        ld0    = n_ld;
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        stream(2, 1024, 1'b1, -1, -1);
        stream(5, 6, 1'b0, -1, -1);
        rst = 1'b1;
        #1;
        chk("rst_mid_b_outputs", outs(), 64'd0);
        chk("seq2_b_writes", 64'(wb_addr.size() - base_b), 64'd1);
        check_a(base_a, 2, "seq2_a");
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", outs(), 64'd0);
        chk("seq2_no_load_done", 64'(n_ld - ld0), 64'd0);

        // Sequence 3: clean restart, then go in the load_done cycle.
        base_a = wa_addr.size();
        base_b = wb_addr.size();
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        stream(3, 1024, 1'b0, -1, -1);
        stream(4, 1024, 1'b0, -1, -1);
        step();
        chk("seq3_start", {63'd0, bus.start}, 64'd1);
        step();
        bus.mmc_done = 1'b1;
        step();
        bus.mmc_done = 1'b0;
        chk("seq3_load_done", {62'd0, bus.load_done, bus.busy}, 64'b11);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        chk("b2b_restart", {61'd0, bus.busy, bus.in_ready, bus.load_done}, 64'b110);
        check_a(base_a, 3, "seq3_a");
        check_b(base_b, 4, "seq3_b");
        chk("seq3_first_b", {24'd0, wb_addr[base_b], wb_data[base_b]}, {24'd0, 8'd0, 32'h0708090A});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
